gemm_tiled_controller: RTL and testbench
========================================

Name: gemm_tiled_controller

Overview:
Loop-nest controller for the multi-MAC GeMM array. It walks ceil(M/MeshRow) x ceil(N/MeshCol) output tiles with an inner ceil(K/TileK) reduction loop, and drives the M/K/N tile counts into the address generators in the accelerator top. Unlike the single-MAC controller, it adds:
- parametrised unroll factors;
- correct handling of sizes that are not multiples of the unroll factors;
- an input ready/valid handshake;
- result backpressure;
- zero-size detection.

Parameters:
AddrWidth, 16, width of size inputs and tile counters
MeshRow, 4, M elements per tile (power of two, >=1)
MeshCol, 4, N elements per tile (power of two, >=1)
TileK, 1, K elements consumed per step (power of two, >=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled in Idle only
M_size_i  in  AddrWidth  rows of A/C, in elements
K_size_i  in  AddrWidth  reduction length, in elements
N_size_i  in  AddrWidth  columns of B/C, in elements
input_valid_i  in  1  operand data valid for current counts
input_ready_o  out  1  controller accepts a step this cycle
acc_clear_o  out  1  current step is the first K step of a tile
result_valid_o  out  1  tile result available
result_ready_i  in  1  downstream accepts the result
busy_o  out  1  state is not Idle
done_o  out  1  one-cycle completion pulse
M_count_o  out  AddrWidth  current M tile index
K_count_o  out  AddrWidth  current K step index
N_count_o  out  AddrWidth  current N tile index
perf_busy_cycles_o  out  32  busy cycle count (see Optional Feature)
perf_stall_cycles_o  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Reset: state Idle. All counts 0. result_valid_o, done_o, busy_o, input_ready_o, acc_clear_o all 0. Latched sizes 0.
- Latching: in Idle, when start_i=1, latch the tile ceilings Mt=ceil(M/MeshRow), Kt=ceil(K/TileK), Nt=ceil(N/MeshCol).
  - Compute each ceiling as (size + unroll - 1) >> log2(unroll), with one extra bit so that the maximum size does not overflow.
  - Size inputs are ignored after the latch.
- States: Idle, Busy, Drain, Finish.
- Idle:
  - start_i with any size == 0 -> Finish. No steps and no results are produced.
  - start_i with all sizes nonzero -> Busy.
- Busy:
  - input_ready_o = !result_valid_o || result_ready_i.
  - step = input_valid_i && input_ready_o.
  - On a step, K increments. When K wraps from Kt-1, N increments. When N wraps from Nt-1, M increments. Loop order is K innermost, then N, then M.
  - acc_clear_o = step && K_count_o == 0.
  - The step with K == Kt-1 sets the registered result_valid_o, visible the next cycle.
  - The step at K=Kt-1, N=Nt-1, M=Mt-1 moves to Drain. All counters hold at their last values.
- result_valid_o:
  - Stays high until result_ready_i is sampled high.
  - If a new tile completes in the same cycle as the acceptance, result_valid_o stays high for the new tile.
- Drain:
  - input_ready_o = 0.
  - When result_valid_o && result_ready_i -> Finish.
- Finish (exactly one cycle):
  - done_o = 1.
  - Counters cleared.
  - -> Idle.
- busy_o is 1 in Busy, Drain and Finish.
- start_i outside Idle is ignored.
- Reset mid-operation returns every output to its reset value in the same cycle (asynchronous reset). No result is emitted afterwards.
- Ceiling 1 on any dimension: the corresponding counter stays at 0 and its last flag is constantly 1.
- Total steps = Mt*Nt*Kt. Total results = Mt*Nt.

Optional Feature:
GEMM_CTRL_PERF_EN
- Defined:
  - perf_busy_cycles_o counts cycles in Busy or Drain.
  - perf_stall_cycles_o counts Busy cycles with input_valid_i=0 or input_ready_o=0.
  - Both are 32-bit, saturating, and cleared when start_i is accepted.
  - They hold their value in Idle so software can read them after done_o.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Package gemm_ctrl_pkg holds:
  - the state enum typedef (Idle/Busy/Drain/Finish, 2 bits);
  - function ceil_div_pow2(size, log2_unroll);
  - localparam PerfWidth=32.
- Sub-module tile_counter:
  - ports: tick, clear, ceiling, count, last_value;
  - last_value = (count == ceiling-1);
  - wraps to 0 on a tick when last.
  - Instantiated three times.

Test Plan:
1. M=8,K=4,N=8, defaults, input_valid_i=1, result_ready_i=1 -> 16 steps; 4 result_valid_o pulses at (M,N)=(0,0),(0,1),(1,0),(1,1); acc_clear_o on steps 0,4,8,12; done_o exactly once, 2 cycles after the last step.
2. M=5,K=3,N=6 -> Mt=2, Nt=2, Kt=3; 12 steps, 4 results; counts never reach M=2 or N=2.
3. M=4,K=2,N=4 with result_ready_i=0 for 5 cycles after the first result -> input_ready_o=0 during the hold; counters frozen; result_valid_o held; resumes on ready; total results 1; done_o after acceptance.
4. K=0 (M=N=4) with start_i -> next cycle Finish with done_o=1; zero steps; result_valid_o never asserted; back to Idle.
5. Mid-run, start_i pulse plus size changes -> ignored; original step count preserved. rst_ni low mid-run -> all outputs 0 immediately; fresh start afterwards runs normally.
6. With GEMM_CTRL_PERF_EN, test 1 with input_valid_i toggling 1/0 -> perf_stall_cycles_o=16, perf_busy_cycles_o=33 (Busy 32 + Drain 1 with immediate ready); without the macro both read 0.

Source files
------------

// File: rtl/gemm_ctrl_pkg.sv
// Shared types and helpers for the tiled GeMM loop-nest controller.
package gemm_ctrl_pkg;

   typedef enum logic [1:0] {
      Idle   = 2'd0,
      Busy   = 2'd1,
      Drain  = 2'd2,
      Finish = 2'd3
   } ctrl_state_e;

   localparam int unsigned PerfWidth = 32;

   // One extra bit keeps (size + unroll - 1) from wrapping at the maximum size.
   function automatic logic [32:0] ceil_div_pow2(input logic [31:0] size,
                                                 input int unsigned log2_unroll);
      logic [32:0] biased;
      biased = {1'b0, size} + ((33'd1 << log2_unroll) - 33'd1);
      return biased >> log2_unroll;
   endfunction

endpackage

// File: rtl/gemm_tiled_controller_tile_counter.sv
// Wrapping tile index counter; last_value flags the final index below the ceiling.
module tile_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick,
   input  logic             clear,
   input  logic [Width:0]   ceiling,
   output logic [Width-1:0] count,
   output logic             last_value
);

   assign last_value = ({1'b0, count} == (ceiling - (Width + 1)'(1)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= last_value ? '0 : count + Width'(1);
      end
   end

endmodule

// File: rtl/gemm_tiled_controller.sv
// Tiled GeMM loop-nest controller (K innermost, then N, then M) with handshakes.
// Optional performance counters are enabled by defining GEMM_CTRL_PERF_EN.
module gemm_tiled_controller
   import gemm_ctrl_pkg::*;
#(
   parameter int unsigned AddrWidth = 16,
   parameter int unsigned MeshRow   = 4,
   parameter int unsigned MeshCol   = 4,
   parameter int unsigned TileK     = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] M_size_i,
   input  logic [AddrWidth-1:0] K_size_i,
   input  logic [AddrWidth-1:0] N_size_i,
   input  logic                 input_valid_i,
   output logic                 input_ready_o,
   output logic                 acc_clear_o,
   output logic                 result_valid_o,
   input  logic                 result_ready_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [AddrWidth-1:0] M_count_o,
   output logic [AddrWidth-1:0] K_count_o,
   output logic [AddrWidth-1:0] N_count_o,
   output logic [31:0]          perf_busy_cycles_o,
   output logic [31:0]          perf_stall_cycles_o
);

   localparam int unsigned LogRow = $clog2(MeshRow);
   localparam int unsigned LogCol = $clog2(MeshCol);
   localparam int unsigned LogK   = $clog2(TileK);
   localparam int unsigned CeilW  = AddrWidth + 1;

   ctrl_state_e          state_q;
   logic [CeilW-1:0]     m_tiles_q, k_tiles_q, n_tiles_q;
   logic                 result_valid_q, done_q, busy_q;
   logic [AddrWidth-1:0] m_count, k_count, n_count;
   logic                 m_last, k_last, n_last;
   logic                 in_ready, step, tile_done, final_step, accept;
   logic                 start_ok, zero_size, cnt_clear;
   logic                 k_tick, n_tick, m_tick;

   always_comb begin
      start_ok   = (state_q == Idle) && start_i;
      zero_size  = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
      in_ready   = (state_q == Busy) && (!result_valid_q || result_ready_i);
      step       = in_ready && input_valid_i;
      tile_done  = step && k_last;
      final_step = tile_done && n_last && m_last;
      accept     = result_valid_q && result_ready_i;
      cnt_clear  = (state_q == Drain) && accept;
      // The final step leaves every index on its last value rather than wrapping.
      k_tick     = step && !final_step;
      n_tick     = tile_done && !final_step;
      m_tick     = tile_done && n_last && !final_step;
   end

   tile_counter #(.Width(AddrWidth)) u_k_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick       (k_tick),
      .clear      (cnt_clear),
      .ceiling    (k_tiles_q),
      .count      (k_count),
      .last_value (k_last)
   );

   tile_counter #(.Width(AddrWidth)) u_n_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick       (n_tick),
      .clear      (cnt_clear),
      .ceiling    (n_tiles_q),
      .count      (n_count),
      .last_value (n_last)
   );

   tile_counter #(.Width(AddrWidth)) u_m_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .tick       (m_tick),
      .clear      (cnt_clear),
      .ceiling    (m_tiles_q),
      .count      (m_count),
      .last_value (m_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= Idle;
         m_tiles_q      <= '0;
         k_tiles_q      <= '0;
         n_tiles_q      <= '0;
         result_valid_q <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         case (state_q)
            Idle: begin
               result_valid_q <= 1'b0;
               done_q         <= 1'b0;
               if (start_i) begin
                  m_tiles_q <= CeilW'(ceil_div_pow2(32'(M_size_i), LogRow));
                  k_tiles_q <= CeilW'(ceil_div_pow2(32'(K_size_i), LogK));
                  n_tiles_q <= CeilW'(ceil_div_pow2(32'(N_size_i), LogCol));
                  busy_q    <= 1'b1;
                  if (zero_size) begin
                     state_q <= Finish;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= Busy;
                  end
               end
            end
            Busy: begin
               // A tile completing on the acceptance cycle keeps valid high.
               if (tile_done) begin
                  result_valid_q <= 1'b1;
               end else if (accept) begin
                  result_valid_q <= 1'b0;
               end
               if (final_step) begin
                  state_q <= Drain;
               end
            end
            Drain: begin
               if (accept) begin
                  result_valid_q <= 1'b0;
                  done_q         <= 1'b1;
                  state_q        <= Finish;
               end
            end
            Finish: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= Idle;
            end
            default: begin
               state_q <= Idle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign input_ready_o  = in_ready;
   assign acc_clear_o    = step && (k_count == '0);
   assign result_valid_o = result_valid_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign M_count_o      = m_count;
   assign K_count_o      = k_count;
   assign N_count_o      = n_count;

`ifdef GEMM_CTRL_PERF_EN
   logic [PerfWidth-1:0] perf_busy_q, perf_stall_q;

   // Saturating counters; they hold through Idle so software can read them after done.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else if (start_ok) begin
         perf_busy_q  <= '0;
         perf_stall_q <= '0;
      end else begin
         if (((state_q == Busy) || (state_q == Drain)) && (perf_busy_q != '1)) begin
            perf_busy_q <= perf_busy_q + PerfWidth'(1);
         end
         if ((state_q == Busy) && !step && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + PerfWidth'(1);
         end
      end
   end

   assign perf_busy_cycles_o  = perf_busy_q;
   assign perf_stall_cycles_o = perf_stall_q;
`else
   assign perf_busy_cycles_o  = '0;
   assign perf_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_gemm_tiled_controller.sv
// Directed bench for gemm_tiled_controller (default parameters, Mesh 4x4, TileK 1).
module tb_gemm_tiled_controller;

   logic        clk_i, rst_ni, start_i;
   logic [15:0] M_size_i, K_size_i, N_size_i;
   logic        input_valid_i, input_ready_o, acc_clear_o;
   logic        result_valid_o, result_ready_i, busy_o, done_o;
   logic [15:0] M_count_o, K_count_o, N_count_o;
   logic [31:0] perf_busy_cycles_o, perf_stall_cycles_o;

`ifdef GEMM_CTRL_PERF_EN
   localparam bit PerfOn = 1'b1;
`else
   localparam bit PerfOn = 1'b0;
`endif

   gemm_tiled_controller dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .start_i             (start_i),
      .M_size_i            (M_size_i),
      .K_size_i            (K_size_i),
      .N_size_i            (N_size_i),
      .input_valid_i       (input_valid_i),
      .input_ready_o       (input_ready_o),
      .acc_clear_o         (acc_clear_o),
      .result_valid_o      (result_valid_o),
      .result_ready_i      (result_ready_i),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .M_count_o           (M_count_o),
      .K_count_o           (K_count_o),
      .N_count_o           (N_count_o),
      .perf_busy_cycles_o  (perf_busy_cycles_o),
      .perf_stall_cycles_o (perf_stall_cycles_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit toggle_valid = 1'b0;

   logic [31:0] step_q[$];
   int clr_cnt, res_cnt, rv_seen, done_cnt, last_step_cyc, done_cyc;
   logic [15:0] done_cnts;

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (input_valid_i && input_ready_o) begin
            step_q.push_back({7'd0, acc_clear_o, M_count_o[7:0], N_count_o[7:0], K_count_o[7:0]});
            last_step_cyc = cyc;
         end
         if (acc_clear_o) clr_cnt++;
         if (result_valid_o) rv_seen++;
         if (result_valid_o && result_ready_i) res_cnt++;
         if (done_o) begin
            done_cnt++;
            done_cyc  = cyc;
            done_cnts = M_count_o | N_count_o | K_count_o;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      step_q.delete();
      clr_cnt = 0; res_cnt = 0; rv_seen = 0; done_cnt = 0;
      last_step_cyc = 0; done_cyc = 0; done_cnts = '0;
   endtask

   task automatic start_op(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n);
      @(posedge clk_i); #1;
      M_size_i = m; K_size_i = k; N_size_i = n;
      start_i = 1'b1;
      input_valid_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (toggle_valid) input_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) begin
         @(posedge clk_i); #1;
         if (toggle_valid) input_valid_i = ~input_valid_i;
      end
      check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
   endtask

   task automatic check_steps(input string tag, input int mt, input int nt, input int kt);
      int idx;
      logic [31:0] exp_t;
      idx = 0;
      check({tag, "_nsteps"}, 32'(step_q.size()), 32'(mt * nt * kt));
      for (int m = 0; m < mt; m++)
         for (int n = 0; n < nt; n++)
            for (int k = 0; k < kt; k++) begin
               exp_t = {7'd0, 1'(k == 0), 8'(m), 8'(n), 8'(k)};
               if (idx < step_q.size()) check({tag, "_step"}, step_q[idx], exp_t);
               idx++;
            end
   endtask

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; input_valid_i = 1'b0; result_ready_i = 1'b1;
      M_size_i = '0; K_size_i = '0; N_size_i = '0;
      clear_logs();

      // Reset state
      @(negedge clk_i);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_rv", 32'(result_valid_o), 32'd0);
      check("rst_ready", 32'(input_ready_o), 32'd0);
      check("rst_counts", 32'(M_count_o | N_count_o | K_count_o), 32'd0);
      @(posedge clk_i); #1 rst_ni = 1'b1;

      // 1: 8x4x8, always valid, always ready
      clear_logs();
      start_op(16'd8, 16'd4, 16'd8);
      wait_done("t1", 200);
      check_steps("t1", 2, 2, 4);
      check("t1_clears", 32'(clr_cnt), 32'd4);
      check("t1_results", 32'(res_cnt), 32'd4);
      check("t1_rv_cycles", 32'(rv_seen), 32'd4);
      check("t1_done_cnt", 32'(done_cnt), 32'd1);
      check("t1_done_lat", 32'(done_cyc - last_step_cyc), 32'd2);
      check("t1_done_counts", 32'(done_cnts), 32'd0);
      check("t1_perf_busy", perf_busy_cycles_o, PerfOn ? 32'd17 : 32'd0);
      check("t1_perf_stall", perf_stall_cycles_o, 32'd0);
      @(negedge clk_i);
      check("t1_idle_busy", 32'(busy_o), 32'd0);

      // 2: non-multiple sizes 5x3x6 -> 2x3x2 tiles, then 1x1x1
      clear_logs();
      start_op(16'd5, 16'd3, 16'd6);
      wait_done("t2", 200);
      check_steps("t2", 2, 2, 3);
      check("t2_results", 32'(res_cnt), 32'd4);
      clear_logs();
      start_op(16'd1, 16'd1, 16'd1);
      wait_done("t2b", 50);
      check_steps("t2b", 1, 1, 1);
      check("t2b_results", 32'(res_cnt), 32'd1);

      // 3: result held off for 5 cycles after the only result
      clear_logs();
      result_ready_i = 1'b0;
      start_op(16'd4, 16'd2, 16'd4);
      for (int i = 0; i < 20 && !result_valid_o; i++) @(negedge clk_i);
      check("t3_rv_seen", 32'(result_valid_o), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("t3_rv_hold", 32'(result_valid_o), 32'd1);
         check("t3_ready_low", 32'(input_ready_o), 32'd0);
         check("t3_k_hold", 32'(K_count_o), 32'd1);
         check("t3_no_done", 32'(done_o), 32'd0);
         @(negedge clk_i);
      end
      @(posedge clk_i); #1 result_ready_i = 1'b1;
      wait_done("t3", 20);
      check_steps("t3", 1, 1, 2);
      check("t3_results", 32'(res_cnt), 32'd1);

      // 3b: backpressure in the middle of the loop freezes the counters
      clear_logs();
      result_ready_i = 1'b0;
      start_op(16'd4, 16'd2, 16'd8);
      for (int i = 0; i < 20 && !result_valid_o; i++) @(negedge clk_i);
      for (int i = 0; i < 3; i++) begin
         check("t3b_ready_low", 32'(input_ready_o), 32'd0);
         check("t3b_n_hold", 32'(N_count_o), 32'd1);
         check("t3b_k_hold", 32'(K_count_o), 32'd0);
         @(negedge clk_i);
      end
      check("t3b_steps_frozen", 32'(step_q.size()), 32'd2);
      @(posedge clk_i); #1 result_ready_i = 1'b1;
      wait_done("t3b", 30);
      check_steps("t3b", 1, 2, 2);
      check("t3b_results", 32'(res_cnt), 32'd2);

      // 4: zero K goes straight to Finish
      clear_logs();
      start_op(16'd4, 16'd0, 16'd4);
      @(negedge clk_i);
      check("t4_done", 32'(done_o), 32'd1);
      check("t4_busy", 32'(busy_o), 32'd1);
      check("t4_ready", 32'(input_ready_o), 32'd0);
      @(negedge clk_i);
      check("t4_idle_busy", 32'(busy_o), 32'd0);
      check("t4_idle_done", 32'(done_o), 32'd0);
      repeat (3) @(negedge clk_i);
      check("t4_steps", 32'(step_q.size()), 32'd0);
      check("t4_rv", 32'(rv_seen), 32'd0);
      check("t4_done_cnt", 32'(done_cnt), 32'd1);

      // 5: start and size changes mid-run are ignored
      clear_logs();
      start_op(16'd8, 16'd4, 16'd8);
      repeat (5) begin @(posedge clk_i); #1; end
      start_i = 1'b1; M_size_i = 16'd2; K_size_i = 16'd2; N_size_i = 16'd2;
      @(posedge clk_i); #1 start_i = 1'b0;
      wait_done("t5", 200);
      check_steps("t5", 2, 2, 4);
      check("t5_results", 32'(res_cnt), 32'd4);

      // 5b: asynchronous reset mid-run, then a fresh run
      start_op(16'd8, 16'd4, 16'd8);
      repeat (5) begin @(posedge clk_i); #1; end
      rst_ni = 1'b0;
      #1;
      check("t5r_busy", 32'(busy_o), 32'd0);
      check("t5r_ready", 32'(input_ready_o), 32'd0);
      check("t5r_clear", 32'(acc_clear_o), 32'd0);
      check("t5r_rv", 32'(result_valid_o), 32'd0);
      check("t5r_counts", 32'(M_count_o | N_count_o | K_count_o), 32'd0);
      @(posedge clk_i); #1 rst_ni = 1'b1;
      clear_logs();
      repeat (4) @(negedge clk_i);
      check("t5r_no_result", 32'(rv_seen), 32'd0);
      check("t5r_idle", 32'(busy_o), 32'd0);
      start_op(16'd4, 16'd4, 16'd4);
      wait_done("t5f", 50);
      check_steps("t5f", 1, 1, 4);
      check("t5f_results", 32'(res_cnt), 32'd1);

      // 6: toggling valid exercises the stall counter
      clear_logs();
      toggle_valid = 1'b1;
      start_op(16'd8, 16'd4, 16'd8);
      wait_done("t6", 200);
      toggle_valid = 1'b0;
      check_steps("t6", 2, 2, 4);
      check("t6_perf_busy", perf_busy_cycles_o, PerfOn ? 32'd33 : 32'd0);
      check("t6_perf_stall", perf_stall_cycles_o, PerfOn ? 32'd16 : 32'd0);
      repeat (3) @(negedge clk_i);
      check("t6_perf_hold", perf_busy_cycles_o, PerfOn ? 32'd33 : 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
